// File: rtl/tree_node_pkg.sv
// Tree node layout, traversal FSM states and the fp32 total-order key.
// Shared by the traverser and by later ensemble blocks that decode tree nodes.
package tree_node_pkg;

  // Node word field positions (bits above FIDX are reserved)
  localparam int unsigned TYPE_LSB  = 0;
  localparam int unsigned TYPE_W    = 4;
  localparam int unsigned RIGHT_LSB = 4;
  localparam int unsigned LEFT_LSB  = 16;
  localparam int unsigned CHILD_W   = 12;
  localparam int unsigned THR_LSB   = 28;
  localparam int unsigned THR_W     = 32;
  localparam int unsigned FIDX_LSB  = 60;
  localparam int unsigned FIDX_W    = 4;

  localparam int unsigned FP32_W    = 32;
  localparam int unsigned ROOT_ADDR = 0;

  localparam logic [TYPE_W-1:0] NODE_INTERNAL = 4'h3;

  typedef logic [FP32_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } state_e;

  // Maps fp32 onto an unsigned key whose ordering matches the float total order
  function automatic logic [FP32_W-1:0] fp32_key(input fp32_t x);
    return x[FP32_W-1] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_le_cmp.sv
// Combinational fp32 a <= b under the IEEE-754 total order (-0.0 < +0.0, NaNs unordered-free).
// Ports: a, b  fp32 operands; le_c  high when a <= b.
module fp32_le_cmp
  import tree_node_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  le_c
);

  assign le_c = (fp32_key(a) <= fp32_key(b));

endmodule

// File: rtl/tree_traverser.sv
// Walks one decision tree held in a 1-cycle registered-read ROM and returns the leaf class.
// Ports: clk/rst (async, active-high); start/features launch a walk (features latched on accept);
//   busy high until the result handshake; rom_addr/rom_data ROM interface;
//   result_valid/result_ready handshake with result_class, result_depth, result_err.
// Build option: TREE_DEPTH_GUARD_EN aborts a walk reaching MAX_DEPTH internal nodes.
module tree_traverser
  import tree_node_pkg::*;
#(
  parameter int unsigned NODE_WIDTH   = 120,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned ROM_DEPTH    = 512,
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned MAX_DEPTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_FEATURES*32-1:0] features,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [NODE_WIDTH-1:0]      rom_data,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       result_class,
  output logic [7:0]                 result_depth,
  output logic                       result_err
);

  localparam int unsigned FEAT_BITS   = NUM_FEATURES * FP32_W;
  localparam int unsigned NODE_USED_W = FIDX_LSB + FIDX_W;

  state_e                 state_q, state_d;
  logic [FEAT_BITS-1:0]   feat_q;
  logic                   load_feat;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [7:0]             depth_d;
  logic                   class_d, err_d, valid_d, busy_d;

  logic [TYPE_W-1:0]      node_type_c;
  logic [FIDX_W-1:0]      fidx_c;
  logic [CHILD_W-1:0]     left_c, right_c, child_c;
  fp32_t                  thr_c, feat_sel_c;
  logic                   le_c, fidx_bad_c, child_bad_c, guard_hit_c;
  logic                   unused_c;

  // Node field decode
  assign node_type_c = rom_data[TYPE_LSB  +: TYPE_W];
  assign right_c     = rom_data[RIGHT_LSB +: CHILD_W];
  assign left_c      = rom_data[LEFT_LSB  +: CHILD_W];
  assign thr_c       = rom_data[THR_LSB   +: THR_W];
  assign fidx_c      = rom_data[FIDX_LSB  +: FIDX_W];
  assign unused_c    = ^{rom_data[NODE_WIDTH-1:NODE_USED_W], 32'(MAX_DEPTH)};

  // Feature mux; an out-of-range index selects zero and is flagged separately
  always_comb begin
    feat_sel_c = '0;
    for (int i = 0; i < int'(NUM_FEATURES); i++) begin
      if (32'(fidx_c) == 32'(i)) feat_sel_c = feat_q[i*FP32_W +: FP32_W];
    end
  end

  fp32_le_cmp u_cmp (
    .a    (feat_sel_c),
    .b    (thr_c),
    .le_c (le_c)
  );

  assign child_c     = le_c ? left_c : right_c;
  assign fidx_bad_c  = (32'(fidx_c) >= NUM_FEATURES);
  assign child_bad_c = (32'(child_c) >= ROM_DEPTH);

`ifdef TREE_DEPTH_GUARD_EN
  assign guard_hit_c = (32'(result_depth) == MAX_DEPTH);
`else
  assign guard_hit_c = 1'b0;
`endif

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    load_feat = 1'b0;
    addr_d    = rom_addr;
    depth_d   = result_depth;
    class_d   = result_class;
    err_d     = result_err;
    valid_d   = result_valid;
    busy_d    = busy;
    case (state_q)
      ST_IDLE: begin
        if (start && !busy) begin
          load_feat = 1'b1;
          addr_d    = ADDR_WIDTH'(ROOT_ADDR);
          depth_d   = 8'd0;
          class_d   = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      // ROM captures rom_addr on this edge
      ST_WAIT: state_d = ST_EVAL;
      ST_EVAL: begin
        if (node_type_c != NODE_INTERNAL) begin
          class_d = rom_data[0];
          state_d = ST_DONE;
        end else if (guard_hit_c || fidx_bad_c || child_bad_c) begin
          class_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = ADDR_WIDTH'(child_c);
          depth_d = (result_depth == 8'hFF) ? 8'hFF : result_depth + 8'd1;
          state_d = ST_WAIT;
        end
      end
      // valid rises one cycle after entering DONE; ready is only honoured once valid is up
      ST_DONE: begin
        if (!result_valid) begin
          valid_d = 1'b1;
        end else if (result_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      feat_q       <= '0;
      rom_addr     <= ADDR_WIDTH'(ROOT_ADDR);
      result_depth <= 8'd0;
      result_class <= 1'b0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (load_feat) feat_q <= features;
      rom_addr     <= addr_d;
      result_depth <= depth_d;
      result_class <= class_d;
      result_err   <= err_d;
      result_valid <= valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_tree_traverser.sv
// Directed bench for tree_traverser: ROM images written by hand, expected results computed by hand.
module tb_tree_traverser;
  import tree_node_pkg::*;

  localparam int unsigned NW = 120;
  localparam int unsigned AW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           ready = 1'b0;
  logic           use8 = 1'b0;
  logic [511:0]   features = '0;
  logic [NW-1:0]  rom [1024];
  logic [NW-1:0]  rd0, rd8;
  logic [AW-1:0]  ra0, ra8;
  logic           busy0, v0, c0, e0, busy8, v8, c8, e8;
  logic [7:0]     d0, d8;
  int             n_total = 0;
  int             n_bad = 0;
  int             addr_log[$];

  wire            s0  = start & ~use8;
  wire            s8  = start & use8;
  wire            r0  = ready & ~use8;
  wire            r8  = ready & use8;
  wire            vm  = use8 ? v8 : v0;
  wire            cm  = use8 ? c8 : c0;
  wire            em  = use8 ? e8 : e0;
  wire            bm  = use8 ? busy8 : busy0;
  wire [7:0]      dm  = use8 ? d8 : d0;
  wire [AW-1:0]   ram = use8 ? ra8 : ra0;

  always #5 clk = ~clk;

  // Registered-read tree ROM, one read port per DUT
  always @(posedge clk) begin
    rd0 <= rom[ra0];
    rd8 <= rom[ra8];
  end

  tree_traverser #(.MAX_DEPTH(4)) u_dut (
    .clk (clk), .rst (rst), .start (s0), .features (features),
    .busy (busy0), .rom_addr (ra0), .rom_data (rd0),
    .result_valid (v0), .result_ready (r0), .result_class (c0),
    .result_depth (d0), .result_err (e0)
  );

  tree_traverser #(.NUM_FEATURES(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (s8), .features (features[255:0]),
    .busy (busy8), .rom_addr (ra8), .rom_data (rd8),
    .result_valid (v8), .result_ready (r8), .result_class (c8),
    .result_depth (d8), .result_err (e8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk_int(input logic [3:0] fi, input logic [31:0] thr,
                                           input logic [11:0] l, input logic [11:0] r);
    return {56'b0, fi, thr, l, r, 4'h3};
  endfunction

  function automatic logic [NW-1:0] mk_leaf(input logic cls);
    return {116'b0, 3'b000, cls};
  endfunction

  function automatic logic [511:0] fv(input int idx, input logic [31:0] val);
    logic [511:0] v;
    v = '0;
    v[32*idx +: 32] = val;
    return v;
  endfunction

  // Returns on the falling edge right after the accepting edge E0
  task automatic launch(input logic [511:0] f);
    @(negedge clk);
    features = f;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // lat = number of rising edges after E0 at which result_valid is first seen
  task automatic wait_res(input int k0, output int lat);
    addr_log.delete();
    addr_log.push_back(32'(ram));
    lat = -1;
    for (int k = k0; k < k0 + 200; k++) begin
      if (vm) begin
        lat = k;
        break;
      end
      @(negedge clk);
      if (32'(ram) != addr_log[$]) addr_log.push_back(32'(ram));
    end
  endtask

  task automatic handshake(input string tag);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({tag, "_drop"}, {30'b0, vm, bm}, 32'd0);
  endtask

  task automatic run_simple(input string tag, input logic [511:0] f,
                            input logic cls, input logic err, input int dep);
    int lat;
    launch(f);
    wait_res(0, lat);
    check({tag, "_lat"}, lat, 32'(2 * dep + 3));
    check({tag, "_res"}, {22'b0, cm, em, dm}, {22'b0, cls, err, 8'(dep)});
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic seen_valid;
    for (int i = 0; i < 1024; i++) rom[i] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_valid", 32'(v0),    32'd0);
    check("rst_res",   {22'b0, c0, e0, d0}, 32'd0);
    check("rst_addr",  32'(ra0),   32'd0);
    rst = 1'b0;

    // Root is a class-1 leaf
    rom[0] = mk_leaf(1'b1);
    launch('0);
    wait_res(0, lat);
    check("root_lat",  lat, 32'd3);
    check("root_res",  {22'b0, c0, e0, d0}, {22'b0, 1'b1, 1'b0, 8'd0});
    check("root_busy", 32'(busy0), 32'd1);
    handshake("root");

    // Three-level walk: 1.5 <= 2.0 -> left (5); 1.5 > 1.0 -> right (9) class 0.
    // A start pulse with f2=3.0 mid-walk must be ignored.
    rom[0] = mk_int(4'd2, 32'h4000_0000, 12'd5, 12'd7);
    rom[5] = mk_int(4'd2, 32'h3F80_0000, 12'd8, 12'd9);
    rom[7] = mk_leaf(1'b1);
    rom[8] = mk_leaf(1'b1);
    rom[9] = mk_leaf(1'b0);
    launch(fv(2, 32'h3FC0_0000));
    features = fv(2, 32'h4040_0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_res(1, lat);
    check("walk_lat",  lat, 32'd7);
    check("walk_nadr", addr_log.size(), 32'd3);
    check("walk_adr0", addr_log[0], 32'd0);
    check("walk_adr1", addr_log[1], 32'd5);
    check("walk_adr2", addr_log[2], 32'd9);
    check("walk_res",  {22'b0, c0, e0, d0}, {22'b0, 1'b0, 1'b0, 8'd2});

    // Back-pressure: outputs hold, start pulses while busy ignored
    for (int j = 0; j < 5; j++) begin
      start = (j == 1 || j == 2);
      @(negedge clk);
      check("hold", {21'b0, v0, c0, e0, d0}, {21'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    end
    start = 1'b0;
    handshake("walk");
    @(negedge clk);
    check("walk_idle", 32'(busy0), 32'd0);

    // Sign and equality handling of the total-order compare
    rom[0]  = mk_int(4'd0, 32'hC040_0000, 12'd20, 12'd21);
    rom[20] = mk_leaf(1'b1);
    rom[21] = mk_leaf(1'b0);
    run_simple("eq_m3",   fv(0, 32'hC040_0000), 1'b1, 1'b0, 1);
    run_simple("m5_le",   fv(0, 32'hC0A0_0000), 1'b1, 1'b0, 1);
    run_simple("m2_gt",   fv(0, 32'hC000_0000), 1'b0, 1'b0, 1);
    rom[0]  = mk_int(4'd0, 32'h8000_0000, 12'd20, 12'd21);
    run_simple("pz_mz",   fv(0, 32'h0000_0000), 1'b0, 1'b0, 1);
    run_simple("mz_mz",   fv(0, 32'h8000_0000), 1'b1, 1'b0, 1);

    // Feature index 15: legal with 16 slots, error with 8
    rom[0] = mk_int(4'hF, 32'h3F80_0000, 12'd20, 12'd21);
    run_simple("fidx15",  fv(15, 32'h3F00_0000), 1'b1, 1'b0, 1);
    use8 = 1'b1;
    run_simple("fidx8",   fv(15, 32'h3F00_0000), 1'b0, 1'b1, 0);
    use8 = 1'b0;

    // Child address bounds
    rom[0]   = mk_int(4'd0, 32'h3F80_0000, 12'h3FF, 12'h1FF);
    rom[511] = mk_leaf(1'b1);
    run_simple("child_oob", fv(0, 32'h3F00_0000), 1'b0, 1'b1, 0);
    run_simple("child_max", fv(0, 32'h4000_0000), 1'b1, 1'b0, 1);

    // Reset while waiting on node 5 of the three-level image
    rom[0] = mk_int(4'd2, 32'h4000_0000, 12'd5, 12'd7);
    launch(fv(2, 32'h3FC0_0000));
    repeat (2) @(negedge clk);
    check("pre_rst", {22'b0, busy0, v0, d0}, {22'b0, 1'b1, 1'b0, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {30'b0, busy0, v0}, 32'd0);
    check("mid_rst_res",  {22'b0, c0, e0, d0}, 32'd0);
    check("mid_rst_addr", 32'(ra0), 32'd0);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_valid = seen_valid | v0 | busy0;
    end
    check("no_partial", 32'(seen_valid), 32'd0);
    rom[0] = mk_leaf(1'b1);
    run_simple("recover", '0, 1'b1, 1'b0, 0);

`ifdef TREE_DEPTH_GUARD_EN
    // Self-looping root is cut off at MAX_DEPTH internal nodes
    rom[0] = mk_int(4'd0, 32'h3F80_0000, 12'd0, 12'd0);
    run_simple("guard", '0, 1'b0, 1'b1, 4);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
